// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory.
// Holds the HALT fill word and the controller state encoding.
package imem_pkg;

  // Fill value for unloaded words and the return value for bad fetches
  localparam logic [31:0] HALT_WORD = 32'hB4221820;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_t;

endpackage

// File: rtl/imem_loadable_if.sv
// Program-load and fetch bus of the instruction memory.
// master: program loader / IF stage side.
// slave : the memory itself.
// Load group : load_start, load_valid, load_addr, load_data, load_last -> memory
//              load_ready, load_err <- memory
// Fetch group: fetch_en, fetch_addr -> memory
//              fetch_inst, fetch_valid, fetch_err, halt_fetched, mem_ready <- memory
interface imem_loadable_if #(
  parameter int unsigned ADDR_W = 12
);

  logic              load_start;
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              load_last;
  logic              load_err;
  logic              fetch_en;
  logic [31:0]       fetch_addr;
  logic [31:0]       fetch_inst;
  logic              fetch_valid;
  logic              fetch_err;
  logic              halt_fetched;
  logic              mem_ready;

  modport master (
    output load_start, load_valid, load_addr, load_data, load_last,
    output fetch_en, fetch_addr,
    input  load_ready, load_err,
    input  fetch_inst, fetch_valid, fetch_err, halt_fetched, mem_ready
  );

  modport slave (
    input  load_start, load_valid, load_addr, load_data, load_last,
    input  fetch_en, fetch_addr,
    output load_ready, load_err,
    output fetch_inst, fetch_valid, fetch_err, halt_fetched, mem_ready
  );

endinterface

// File: rtl/imem_ram.sv
// Single-port synchronous RAM, DEPTH x 32, with registered read.
// Ports: clk; we/wdata write at addr; re loads rdata from addr (rdata holds otherwise).
module imem_ram #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned IDX_W = 12
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // Storage array and read register; contents are defined by the FILL pass, not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory with runtime program load.
// After reset every word is overwritten with HALT_WORD (FILL), then the memory
// serves registered fetches (RUN); load_start opens a LOAD window in which
// valid beats write words until the beat flagged load_last.
// Ports: clk, reset (sync, active-high), bus (imem_loadable_if.slave: load and fetch groups).
module imem_loadable #(
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter logic [31:0] HALT_WORD = imem_pkg::HALT_WORD
) (
  input  logic           clk,
  input  logic           reset,
  imem_loadable_if.slave bus
);

  import imem_pkg::*;

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] fill_cnt_q, fill_cnt_d;

  logic             load_ready_q, load_ready_d;
  logic             load_err_q, load_err_d;
  logic             mem_ready_q, mem_ready_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             fetch_err_q, fetch_err_d;
  logic             sel_halt_q, sel_halt_d;

  logic             ram_we, ram_re;
  logic [IDX_W-1:0] ram_addr;
  logic [31:0]      ram_wdata, ram_rdata;

  logic             fetch_go, fetch_bad, load_oor;

  assign fetch_go  = (state_q == RUN) && bus.fetch_en;
  assign fetch_bad = (bus.fetch_addr[1:0] != 2'b00) ||
                     (32'(bus.fetch_addr[31:2]) >= 32'(DEPTH));
  assign load_oor  = 32'(bus.load_addr) >= 32'(DEPTH);

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FILL;
      fill_cnt_q    <= '0;
      load_ready_q  <= 1'b0;
      load_err_q    <= 1'b0;
      mem_ready_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      sel_halt_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      load_ready_q  <= load_ready_d;
      load_err_q    <= load_err_d;
      mem_ready_q   <= mem_ready_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
      sel_halt_q    <= sel_halt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: if (fill_cnt_q == IDX_W'(DEPTH - 1)) state_d = RUN;
      RUN:  if (bus.load_start) state_d = LOAD;
      LOAD: if (bus.load_valid && bus.load_last) state_d = RUN;
      default: state_d = FILL;
    endcase
  end

  // RAM port ownership and next values of the registered outputs
  always_comb begin
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;
    fill_cnt_d    = '0;
    load_err_d    = load_err_q;
    fetch_valid_d = fetch_go;
    fetch_err_d   = fetch_go && fetch_bad;
    // Keep the HALT override of the last honoured fetch so fetch_inst holds
    sel_halt_d    = fetch_go ? fetch_bad : sel_halt_q;
    mem_ready_d   = (state_d == RUN);
    load_ready_d  = (state_d == LOAD);

    unique case (state_q)
      FILL: begin
        ram_we     = 1'b1;
        ram_addr   = fill_cnt_q;
        ram_wdata  = HALT_WORD;
        fill_cnt_d = fill_cnt_q + IDX_W'(1);
      end
      RUN: begin
        ram_re   = fetch_go;
        ram_addr = bus.fetch_addr[IDX_W+1:2];
        if (bus.load_start) load_err_d = 1'b0;
      end
      LOAD: begin
        ram_addr  = bus.load_addr[IDX_W-1:0];
        ram_wdata = bus.load_data;
        if (bus.load_valid) begin
          if (load_oor) load_err_d = 1'b1;
          else          ram_we     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  imem_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign bus.load_ready   = load_ready_q;
  assign bus.load_err     = load_err_q;
  assign bus.mem_ready    = mem_ready_q;
  assign bus.fetch_valid  = fetch_valid_q;
  assign bus.fetch_err    = fetch_err_q;
  assign bus.fetch_inst   = sel_halt_q ? HALT_WORD : ram_rdata;
  assign bus.halt_fetched = fetch_valid_q && (bus.fetch_inst == HALT_WORD);

endmodule
